p66b_txgearbox_param: RTL



---
 rtl/p66b_pkg.sv | 13 +
 rtl/p66b_txgearbox_param.sv | 72 +++++++
 2 files changed

// File: rtl/p66b_pkg.sv
// p66b_pkg: shared 64b/66b constants and the gearbox merge helper.
package p66b_pkg;
  localparam logic [1:0] P66B_SYNC_DATA = 2'b01;
  localparam logic [1:0] P66B_SYNC_CTRL = 2'b10;
  localparam logic [65:0] P66B_IDLE_BLOCK = {56'h0, 8'h1E, P66B_SYNC_CTRL};
  localparam int P66B_BW = 256;
  localparam int P66B_PW = 8;
  function automatic logic [P66B_BW-1:0] merge_at(input logic [P66B_BW-1:0] b,
                                                  input logic [P66B_BW-1:0] blk,
                                                  input logic [P66B_PW-1:0] pos);
    return b | (blk << pos);
  endfunction
endpackage

// File: rtl/p66b_txgearbox_param.sv
// p66b_txgearbox_param: packs IW-bit blocks into OW-bit words LSB first,
// merging FILL_WORD whenever a slot opens with no source block available.
module p66b_txgearbox_param
  import p66b_pkg::*;
#(
  parameter int IW = 66,
  parameter int OW = 64,
  parameter logic [IW-1:0] FILL_WORD = P66B_IDLE_BLOCK,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic [IW-1:0] S_DATA,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_underflow,
  output logic [CW-1:0] o_underflow_count
);
  localparam int BW = IW + OW;
  localparam int FW = $clog2(BW) + 1;

  if (IW < OW || BW > P66B_BW) begin : g_bad_width
    $error("p66b_txgearbox_param: illegal IW/OW combination");
  end

  logic [BW-1:0] buf_q, buf_d;
  logic [FW-1:0] fill_q, fill_d, rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          uf_q, uf_d, slot, take;

  assign rem = fill_q - FW'(OW);
  assign slot = rem < FW'(OW);
  // Reset gating keeps the handshake closed while the buffer is being cleared.
  assign S_READY = i_reset_n && i_ready && slot;
  assign o_data = buf_q[OW-1:0];
  assign o_underflow = uf_q;
  assign o_underflow_count = cnt_q;

  always_comb begin
    take = i_ready && slot;
    buf_d = i_ready ? (take ? BW'(merge_at(P66B_BW'(buf_q >> OW),
                                           P66B_BW'(S_VALID ? S_DATA : FILL_WORD),
                                           P66B_PW'(rem)))
                            : buf_q >> OW)
                    : buf_q;
    fill_d = i_ready ? (take ? rem + FW'(IW) : rem) : fill_q;
    uf_d = take && !S_VALID;
    cnt_d = (uf_d && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buf_q <= '0;
      fill_q <= FW'(OW);
      uf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      fill_q <= fill_d;
      uf_q <= uf_d;
      cnt_q <= cnt_d;
    end
  end

  // Bits above the fill level must stay clear, or a merge would corrupt live data.
  a_fill_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    fill_q >= FW'(OW) && fill_q <= FW'(BW - 1));
  a_no_overlap: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (buf_q >> fill_q) == '0);
endmodule
